fir_coef_loader: RTL

//  Double-buffered coefficient controller for the decimated-rate FIR stage of the LPF/decimator chain.

---
 rtl/fir_coef_loader_pkg.sv | 21 ++
 rtl/fir_coef_loader_coef_bank.sv | 36 +++
 rtl/fir_coef_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fir_coef_loader_pkg.sv
// Shared definitions for the FIR coefficient loader: FSM encoding, default geometry
// and the unity-gain coefficient helper.
package fir_coef_loader_pkg;

   localparam int N_TAPS_DEF   = 32;
   localparam int W_COEF_DEF   = 16;
   localparam int W_ADDR_DEF   = 5;
   localparam int LOAD_CNT_MAX = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PEND = 2'd2
   } ld_state_t;

   // Unity gain in the FIR's Q(W-2) coefficient format.
   function automatic int coef_unity(input int w);
      return 1 << (w - 2);
   endfunction

endpackage

// File: rtl/fir_coef_loader_coef_bank.sv
// One coefficient bank: N_TAPS x W_COEF registers, single write port, registered read,
// and a parameterised reset image.
module coef_bank
   import fir_coef_loader_pkg::*;
#(
   parameter int                          N_TAPS    = N_TAPS_DEF,
   parameter int                          W_COEF    = W_COEF_DEF,
   parameter int                          W_ADDR    = W_ADDR_DEF,
   parameter logic [N_TAPS*W_COEF-1:0]    RST_IMAGE = '0
) (
   input  logic              clk_dec,
   input  logic              reset_b,
   input  logic              wr_en,
   input  logic [W_ADDR-1:0] wr_addr,
   input  logic [W_COEF-1:0] wr_data,
   input  logic [W_ADDR-1:0] rd_addr,
   output logic [W_COEF-1:0] rd_data
);

   logic [N_TAPS-1:0][W_COEF-1:0] mem;
   logic                          rd_in_range;

   // Addresses past the last tap read as zero so a short FIR walk sees no garbage.
   assign rd_in_range = ({1'b0, rd_addr} < (W_ADDR+1)'(N_TAPS));

   always_ff @(posedge clk_dec or negedge reset_b) begin
      if (!reset_b) begin
         mem     <= RST_IMAGE;
         rd_data <= '0;
      end else begin
         if (wr_en) mem[wr_addr] <= wr_data;
         rd_data <= rd_in_range ? mem[rd_addr] : '0;
      end
   end

endmodule

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader: streams a set into the shadow bank and makes it
// live only on a frame-boundary swap strobe.
module fir_coef_loader
   import fir_coef_loader_pkg::*;
#(
   parameter int N_TAPS = N_TAPS_DEF,
   parameter int W_COEF = W_COEF_DEF,
   parameter int W_ADDR = W_ADDR_DEF
) (
   input  logic              clk_dec,
   input  logic              reset_b,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [W_COEF-1:0] cfg_data,
   input  logic              cfg_last,
   input  logic              cfg_abort,
   input  logic              swap_en,
   input  logic [W_ADDR-1:0] coef_rd_addr,
   output logic [W_COEF-1:0] coef_rd_data,
   output logic              active_bank,
   output logic              swap_done,
   output logic              err_len,
   output logic [7:0]        load_cnt
);

   localparam int                       N_BANKS  = 2;
   localparam logic [W_ADDR-1:0]        LAST_IDX = W_ADDR'(N_TAPS - 1);
   localparam logic [N_TAPS*W_COEF-1:0] IMG_PASS = (N_TAPS*W_COEF)'(coef_unity(W_COEF));

   ld_state_t                         state;
   logic [W_ADDR-1:0]                 wr_idx;
   logic                              rd_sel;
   logic                              xfer;
   logic                              wr_en;
   logic                              shadow_bank;
   logic [N_BANKS-1:0]                bank_we;
   logic [N_BANKS-1:0][W_COEF-1:0]    bank_rd;

   assign xfer        = cfg_valid & cfg_ready;
   assign shadow_bank = ~active_bank;
   assign wr_en       = xfer & ~(cfg_abort & (state == ST_LOAD));

   // rd_sel lags active_bank by one edge so a read issued on the swap edge still
   // returns the outgoing set.
   assign coef_rd_data = bank_rd[rd_sel];

   for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
      assign bank_we[b] = wr_en & (shadow_bank == 1'(b));

      coef_bank #(
         .N_TAPS    (N_TAPS),
         .W_COEF    (W_COEF),
         .W_ADDR    (W_ADDR),
         .RST_IMAGE ((b == 0) ? IMG_PASS : '0)
      ) u_bank (
         .clk_dec (clk_dec),
         .reset_b (reset_b),
         .wr_en   (bank_we[b]),
         .wr_addr (wr_idx),
         .wr_data (cfg_data),
         .rd_addr (coef_rd_addr),
         .rd_data (bank_rd[b])
      );
   end

   always_ff @(posedge clk_dec or negedge reset_b) begin
      if (!reset_b) begin
         state       <= ST_IDLE;
         wr_idx      <= '0;
         active_bank <= 1'b0;
         rd_sel      <= 1'b0;
         cfg_ready   <= 1'b0;
         swap_done   <= 1'b0;
         err_len     <= 1'b0;
         load_cnt    <= '0;
      end else begin
         swap_done <= 1'b0;
         err_len   <= 1'b0;
         rd_sel    <= active_bank;
         cfg_ready <= (state != ST_PEND);
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  if (cfg_last) begin
                     err_len <= 1'b1;
                  end else begin
                     wr_idx <= W_ADDR'(1);
                     state  <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (cfg_abort) begin
                  state  <= ST_IDLE;
                  wr_idx <= '0;
               end else if (xfer) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_idx <= '0;
                     if (cfg_last) begin
                        state     <= ST_PEND;
                        cfg_ready <= 1'b0;
                     end else begin
                        err_len <= 1'b1;
                        state   <= ST_IDLE;
                     end
                  end else if (cfg_last) begin
                     err_len <= 1'b1;
                     wr_idx  <= '0;
                     state   <= ST_IDLE;
                  end else begin
                     wr_idx <= wr_idx + W_ADDR'(1);
                  end
               end
            end
            ST_PEND: begin
               if (cfg_abort) begin
                  state     <= ST_IDLE;
                  cfg_ready <= 1'b1;
               end else if (swap_en) begin
                  active_bank <= ~active_bank;
                  swap_done   <= 1'b1;
                  cfg_ready   <= 1'b1;
                  state       <= ST_IDLE;
                  if (load_cnt != 8'(LOAD_CNT_MAX)) load_cnt <= load_cnt + 8'd1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               wr_idx <= '0;
            end
         endcase
      end
   end

endmodule
